capacitive_touch_detector: RTL and testbench
============================================

CAPACITIVE_TOUCH_DETECTOR -- requirements
Module: capacitive_touch_detector

Interface
REQ-001 SHALL have parameter NUM_PADS, default 9, number of capacitive pads.
REQ-002 SHALL have parameter SCAN_DIV, default 50000, clock cycles between scan ticks.
REQ-003 SHALL have parameter CAL_SCANS, default 16, calibration scans; power of two only.
REQ-004 SHALL have parameter THRESHOLD, default 200, counts above baseline that mean touched.
REQ-005 SHALL have parameter DEBOUNCE, default 3, consecutive agreeing scans needed to change pad state.
REQ-006 SHALL have port clock, input, 1, the single clock; all logic is on its rising edge.
REQ-007 SHALL have port reset, input, 1; reset is synchronous and active-high.
REQ-008 SHALL have port readings, input, 32*NUM_PADS; pad i raw count at bits [32i+31:32i], unsigned, from capacitive_sensor_array.
REQ-009 SHALL have port recal, input, 1, single-cycle request to restart calibration.
REQ-010 SHALL have port hit_ack, input, NUM_PADS, per-pad clear of hit_pending, from the processor.
REQ-011 SHALL have port touched, output, NUM_PADS, debounced level per pad.
REQ-012 SHALL have port hit_pending, output, NUM_PADS, sticky per-pad rising-edge events.
REQ-013 SHALL have port calibrated, output, 1, high once the baselines are valid.
REQ-014 SHALL have port scan_done, output, 1, one-cycle pulse after pad NUM_PADS-1 is evaluated.

Function
REQ-015 SHALL assert a scan tick every SCAN_DIV cycles from a free-running counter that restarts at 0 after reset or recal.
REQ-016 SHALL snapshot all readings into an internal register on the tick cycle; a scan uses only this snapshot.
REQ-017 SHALL have FSM states IDLE and SCAN; IDLE->SCAN on tick; in SCAN it evaluates pad index p=0..NUM_PADS-1, one pad per cycle; after p=NUM_PADS-1 it returns to IDLE and pulses scan_done.
REQ-018 SHALL ignore a tick that arrives while in SCAN; requires SCAN_DIV > NUM_PADS+1.
REQ-019 SHALL, while calibrated=0, add each pad's snapshot into a 32+log2(CAL_SCANS)-bit accumulator instead of detecting; touched and hit_pending stay 0.
REQ-020 SHALL, at the end of scan number CAL_SCANS, set baseline[i] = acc[i] >> log2(CAL_SCANS) and assert calibrated on the next cycle.
REQ-021 SHALL, when calibrated=1, compute the raw-touch bit = snapshot[i] > limit[i], where limit[i] = baseline[i]+THRESHOLD saturated at 32'hFFFFFFFF; the compare is unsigned.
REQ-022 SHALL keep a per-pad debounce counter: if raw equals touched[i], the counter is cleared; otherwise it increments, and on reaching DEBOUNCE touched[i] toggles and the counter clears.
REQ-023 SHALL update touched[i] in the cycle after pad i's evaluation cycle; worst-case latency from the snapshot is DEBOUNCE scans plus i+1 cycles.
REQ-024 SHALL set hit_pending[i] on the same cycle touched[i] goes 0->1; a 1->0 transition has no event.
REQ-025 SHALL clear hit_pending[i] when hit_ack[i]=1, unless a set occurs in the same cycle; set wins.
REQ-026 SHALL, on recal in any state including mid-scan, next cycle: FSM to IDLE, p=0, calibrated=0, accumulators, debounce counters, touched and hit_pending cleared, tick counter restarted.

Reset
REQ-027 SHALL, on reset, set touched=0, hit_pending=0, calibrated=0, scan_done=0, FSM=IDLE, p=0, counters, accumulators and baselines to 0, so calibration restarts.
REQ-028 SHALL give reset priority over recal, tick and hit_ack in the same cycle.

Structure
REQ-029 SHALL place NUM_PADS, the reading width (32), FSM state encoding and the default parameter values in the shared package touch_pkg.
REQ-030 SHALL implement the tick counter as sub-module scan_tick_gen with inputs clock, reset and restart and output tick; the pad datapath is time-multiplexed with one comparator and one adder.

Verification
Bench parameters: SCAN_DIV=8, CAL_SCANS=4, THRESHOLD=100, DEBOUNCE=2.
REQ-031 SHALL test calibration: all pads held at 1000 for 4 scans -> calibrated rises after scan 4, all baselines 1000, touched=0.
REQ-032 SHALL test touch and debounce: pad 3 set to 1101 -> touched[3]=1 and hit_pending[3]=1 after 2 scans; a value of 1100 never sets it.
REQ-033 SHALL test a glitch: pad 5 at 1500 for one scan, then 1000 -> touched[5] stays 0 and no event.
REQ-034 SHALL test the ack race: hit_ack[3] in the same cycle as a new set of hit_pending[3] -> hit_pending[3]=1; a later lone ack -> 0.
REQ-035 SHALL test saturation: baseline 32'hFFFFFFF0 with reading 32'hFFFFFFFF -> no touch.
REQ-036 SHALL test recal and reset: recal on scan cycle p=4 -> next cycle all outputs 0 and recalibration completes after 4 scans; a synchronous reset asserted with recal -> reset state.

Source files
------------

// File: rtl/touch_pkg.sv
// Shared constants for the capacitive touch detector.
// Holds default parameters, reading width and FSM encoding.
package touch_pkg;

    localparam int NUM_PADS_DEF  = 9;
    localparam int SCAN_DIV_DEF  = 50000;
    localparam int CAL_SCANS_DEF = 16;
    localparam int THRESHOLD_DEF = 200;
    localparam int DEBOUNCE_DEF  = 3;

    localparam int RD_W = 32;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SCAN = 1'b1;

endpackage

// File: rtl/scan_tick_gen.sv
// Free-running scan tick divider.
// Pulses tick once every DIV cycles; restart forces the count back to 0.
module scan_tick_gen
    import touch_pkg::*;
#(
    parameter int DIV = SCAN_DIV_DEF
) (
    input  logic clock,
    input  logic reset,
    input  logic restart,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick = (cnt_q == CW'(DIV - 1));

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (restart || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/capacitive_touch_detector.sv
// Capacitive touch detector: calibrates per-pad baselines, then
// debounces threshold crossings with one shared adder/comparator.
module capacitive_touch_detector
    import touch_pkg::*;
#(
    parameter int NUM_PADS  = NUM_PADS_DEF,
    parameter int SCAN_DIV  = SCAN_DIV_DEF,
    parameter int CAL_SCANS = CAL_SCANS_DEF,
    parameter int THRESHOLD = THRESHOLD_DEF,
    parameter int DEBOUNCE  = DEBOUNCE_DEF
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [RD_W*NUM_PADS-1:0] readings,
    input  logic                     recal,
    input  logic [NUM_PADS-1:0]      hit_ack,
    output logic [NUM_PADS-1:0]      touched,
    output logic [NUM_PADS-1:0]      hit_pending,
    output logic                     calibrated,
    output logic                     scan_done
);

    localparam int LG    = $clog2(CAL_SCANS);
    localparam int ACC_W = RD_W + LG;
    localparam int SUM_W = ACC_W + 1;
    localparam int PW    = (NUM_PADS > 1) ? $clog2(NUM_PADS) : 1;
    localparam int DW    = $clog2(DEBOUNCE + 1);
    localparam int CW    = LG + 1;

    logic                tick;
    logic [0:0]          state_q, state_d;
    logic [PW-1:0]       p_q, p_d;
    logic [CW-1:0]       cal_cnt_q, cal_cnt_d;
    logic                calibrated_q, calibrated_d;
    logic                scan_done_q, scan_done_d;
    logic [NUM_PADS-1:0] touched_q, touched_d;
    logic [NUM_PADS-1:0] hit_q, hit_d;
    logic [NUM_PADS-1:0] set_vec;

    logic [RD_W-1:0]  snap_q [NUM_PADS];
    logic [RD_W-1:0]  snap_d [NUM_PADS];
    logic [RD_W-1:0]  base_q [NUM_PADS];
    logic [RD_W-1:0]  base_d [NUM_PADS];
    logic [ACC_W-1:0] acc_q  [NUM_PADS];
    logic [ACC_W-1:0] acc_d  [NUM_PADS];
    logic [DW-1:0]    dbc_q  [NUM_PADS];
    logic [DW-1:0]    dbc_d  [NUM_PADS];

    logic [RD_W-1:0]  cur;
    logic [SUM_W-1:0] op_a, op_b, sum;
    logic [RD_W-1:0]  limit;
    logic [DW-1:0]    dbc_inc;
    logic             raw;
    logic             last_pad;
    logic             last_cal;

    scan_tick_gen #(
        .DIV(SCAN_DIV)
    ) u_tick (
        .clock  (clock),
        .reset  (reset),
        .restart(recal),
        .tick   (tick)
    );

    // One adder serves both accumulation and baseline+threshold.
    always_comb begin
        cur      = snap_q[p_q];
        op_a     = calibrated_q ? SUM_W'(base_q[p_q]) : SUM_W'(acc_q[p_q]);
        op_b     = calibrated_q ? SUM_W'(THRESHOLD) : SUM_W'(cur);
        sum      = op_a + op_b;
        limit    = (|sum[SUM_W-1:RD_W]) ? {RD_W{1'b1}} : sum[RD_W-1:0];
        raw      = cur > limit;
        dbc_inc  = dbc_q[p_q] + 1'b1;
        last_pad = (p_q == PW'(NUM_PADS - 1));
        last_cal = (cal_cnt_q == CW'(CAL_SCANS - 1));
    end

    always_comb begin
        state_d      = state_q;
        p_d          = p_q;
        cal_cnt_d    = cal_cnt_q;
        calibrated_d = calibrated_q;
        scan_done_d  = 1'b0;
        touched_d    = touched_q;
        set_vec      = '0;
        snap_d       = snap_q;
        base_d       = base_q;
        acc_d        = acc_q;
        dbc_d        = dbc_q;

        unique case (state_q)
            ST_IDLE: begin
                if (tick) begin
                    state_d = ST_SCAN;
                    p_d     = '0;
                    for (int i = 0; i < NUM_PADS; i++) begin
                        snap_d[i] = readings[RD_W*i +: RD_W];
                    end
                end
            end
            ST_SCAN: begin
                if (!calibrated_q) begin
                    acc_d[p_q] = sum[ACC_W-1:0];
                    if (last_cal) begin
                        base_d[p_q] = sum[LG +: RD_W];
                    end
                end else if (raw == touched_q[p_q]) begin
                    dbc_d[p_q] = '0;
                end else if (dbc_inc == DW'(DEBOUNCE)) begin
                    dbc_d[p_q]     = '0;
                    touched_d[p_q] = raw;
                    set_vec[p_q]   = raw;
                end else begin
                    dbc_d[p_q] = dbc_inc;
                end

                if (last_pad) begin
                    state_d     = ST_IDLE;
                    p_d         = '0;
                    scan_done_d = 1'b1;
                    if (!calibrated_q) begin
                        cal_cnt_d = cal_cnt_q + 1'b1;
                        if (last_cal) begin
                            calibrated_d = 1'b1;
                        end
                    end
                end else begin
                    p_d = p_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        hit_d = (hit_q & ~hit_ack) | set_vec;

        // Baselines survive recal; they are rewritten by the next calibration.
        if (recal) begin
            state_d      = ST_IDLE;
            p_d          = '0;
            cal_cnt_d    = '0;
            calibrated_d = 1'b0;
            scan_done_d  = 1'b0;
            touched_d    = '0;
            hit_d        = '0;
            for (int i = 0; i < NUM_PADS; i++) begin
                acc_d[i] = '0;
                dbc_d[i] = '0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            p_q          <= '0;
            cal_cnt_q    <= '0;
            calibrated_q <= 1'b0;
            scan_done_q  <= 1'b0;
            touched_q    <= '0;
            hit_q        <= '0;
            for (int i = 0; i < NUM_PADS; i++) begin
                snap_q[i] <= '0;
                base_q[i] <= '0;
                acc_q[i]  <= '0;
                dbc_q[i]  <= '0;
            end
        end else begin
            state_q      <= state_d;
            p_q          <= p_d;
            cal_cnt_q    <= cal_cnt_d;
            calibrated_q <= calibrated_d;
            scan_done_q  <= scan_done_d;
            touched_q    <= touched_d;
            hit_q        <= hit_d;
            snap_q       <= snap_d;
            base_q       <= base_d;
            acc_q        <= acc_d;
            dbc_q        <= dbc_d;
        end
    end

    assign touched     = touched_q;
    assign hit_pending = hit_q;
    assign calibrated  = calibrated_q;
    assign scan_done   = scan_done_q;

endmodule

// File: tb/tb_capacitive_touch_detector.sv
// Directed bench for capacitive_touch_detector.
// Six pads, SCAN_DIV=8, CAL_SCANS=4, THRESHOLD=100, DEBOUNCE=2.
module tb_capacitive_touch_detector;

    localparam int NP = 6;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              recal = 1'b0;
    logic [32*NP-1:0]  readings;
    logic [NP-1:0]     hit_ack = '0;
    logic [NP-1:0]     touched;
    logic [NP-1:0]     hit_pending;
    logic              calibrated;
    logic              scan_done;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    capacitive_touch_detector #(
        .NUM_PADS (NP),
        .SCAN_DIV (8),
        .CAL_SCANS(4),
        .THRESHOLD(100),
        .DEBOUNCE (2)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .readings   (readings),
        .recal      (recal),
        .hit_ack    (hit_ack),
        .touched    (touched),
        .hit_pending(hit_pending),
        .calibrated (calibrated),
        .scan_done  (scan_done)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_all(input logic [31:0] v);
        for (int i = 0; i < NP; i++) readings[32*i +: 32] = v;
    endtask

    task automatic set_pad(input int i, input logic [31:0] v);
        readings[32*i +: 32] = v;
    endtask

    // Returns at the negedge of the cycle where scan_done is high.
    task automatic wait_scan();
        int n = 0;
        @(negedge clock);
        while (!scan_done && n < 40) begin
            @(negedge clock);
            n++;
        end
        if (!scan_done) check("scan_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_scans(input int k);
        for (int i = 0; i < k; i++) wait_scan();
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_touched"}, 32'(touched), 32'd0);
        check({tag, "_hit"}, 32'(hit_pending), 32'd0);
        check({tag, "_cal"}, 32'(calibrated), 32'd0);
        check({tag, "_done"}, 32'(scan_done), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int n;
        int seen;

        set_all(32'd1000);
        repeat (3) @(negedge clock);
        reset = 1'b0;
        check_idle("reset");

        wait_scans(3);
        check("cal_pre", 32'(calibrated), 32'd0);
        wait_scan();
        check("cal_done", 32'(calibrated), 32'd1);
        check("cal_touch", 32'(touched), 32'd0);
        @(negedge clock);
        check("done_pulse", 32'(scan_done), 32'd0);

        set_pad(3, 32'd1100);
        wait_scans(3);
        check("at_limit_touch", 32'(touched), 32'd0);
        check("at_limit_hit", 32'(hit_pending), 32'd0);

        set_pad(3, 32'd1101);
        wait_scan();
        check("deb_one", 32'(touched[3]), 32'd0);
        wait_scan();
        check("touch3", 32'(touched), 32'h08);
        check("hit3", 32'(hit_pending), 32'h08);

        set_pad(3, 32'd1000);
        wait_scans(2);
        check("release3", 32'(touched[3]), 32'd0);
        check("no_fall_event", 32'(hit_pending[3]), 32'd1);

        hit_ack = 6'b001000;
        @(negedge clock);
        hit_ack = '0;
        check("lone_ack", 32'(hit_pending[3]), 32'd0);

        set_pad(3, 32'd1101);
        hit_ack = 6'b001000;
        n = 0;
        while (!touched[3] && n < 100) begin
            @(negedge clock);
            n++;
        end
        hit_ack = '0;
        check("race_touch", 32'(touched[3]), 32'd1);
        check("race_set_wins", 32'(hit_pending[3]), 32'd1);
        @(negedge clock);
        check("race_hold", 32'(hit_pending[3]), 32'd1);
        hit_ack = 6'b001000;
        @(negedge clock);
        hit_ack = '0;
        check("later_ack", 32'(hit_pending[3]), 32'd0);

        set_pad(3, 32'd1000);
        wait_scans(3);
        check("release3b", 32'(touched[3]), 32'd0);

        set_pad(5, 32'd1500);
        wait_scan();
        check("glitch_one", 32'(touched[5]), 32'd0);
        set_pad(5, 32'd1000);
        wait_scans(2);
        check("glitch_touch", 32'(touched[5]), 32'd0);
        check("glitch_hit", 32'(hit_pending[5]), 32'd0);

        set_pad(3, 32'd1101);
        wait_scans(2);
        check("pre_recal_touch", 32'(touched[3]), 32'd1);
        check("pre_recal_hit", 32'(hit_pending[3]), 32'd1);
        set_pad(3, 32'd1000);
        // Tick is the next cycle; pad 4 is evaluated five cycles after it.
        repeat (6) @(negedge clock);
        recal = 1'b1;
        @(negedge clock);
        recal = 1'b0;
        check_idle("recal");
        seen = 0;
        repeat (8) begin
            @(negedge clock);
            if (scan_done) seen = 1;
        end
        check("recal_abort", 32'(seen), 32'd0);
        wait_scans(3);
        check("recal_cal_pre", 32'(calibrated), 32'd0);
        wait_scan();
        check("recal_cal_done", 32'(calibrated), 32'd1);
        set_pad(3, 32'd1101);
        wait_scans(2);
        check("recal_base", 32'(touched), 32'h08);

        @(negedge clock);
        reset = 1'b1;
        recal = 1'b1;
        hit_ack = '1;
        set_all(32'hFFFF_FFF0);
        @(negedge clock);
        reset = 1'b0;
        recal = 1'b0;
        hit_ack = '0;
        check_idle("rst_recal");

        wait_scans(4);
        check("sat_cal", 32'(calibrated), 32'd1);
        set_pad(0, 32'hFFFF_FFFF);
        wait_scans(3);
        check("sat_touch", 32'(touched), 32'd0);
        check("sat_hit", 32'(hit_pending), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
